// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// ALUOp values (also consumed by ALUControl) and datapath mux selects.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC_R = 4'd2,
        ST_WB_R   = 4'd3,
        ST_EXEC_I = 4'd4,
        ST_WB_I   = 4'd5,
        ST_ADDR   = 4'd6,
        ST_MEM_RD = 4'd7,
        ST_WB_MEM = 4'd8,
        ST_MEM_WR = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALUOP_NONE = 4'b0000;
    localparam logic [3:0] ALUOP_LW   = 4'b0001;
    localparam logic [3:0] ALUOP_SW   = 4'b0010;
    localparam logic [3:0] ALUOP_BR   = 4'b0011;
    localparam logic [3:0] ALUOP_ADD  = 4'b0100;
    localparam logic [3:0] ALUOP_ORI  = 4'b0101;
    localparam logic [3:0] ALUOP_LUI  = 4'b0110;
    localparam logic [3:0] ALUOP_R    = 4'b1111;

    localparam logic       SRC_A_PC      = 1'b0;
    localparam logic       SRC_A_RS      = 1'b1;
    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    // Post-DECODE state for an opcode; ST_FETCH marks an unsupported opcode.
    function automatic state_e decode_target(input logic [5:0] op, input logic jal_en);
        state_e tgt;
        case (op)
            OP_RTYPE:                tgt = ST_EXEC_R;
            OP_ADDI, OP_ORI, OP_LUI: tgt = ST_EXEC_I;
            OP_LW, OP_SW:            tgt = ST_ADDR;
            OP_BEQ, OP_BNE:          tgt = ST_BRANCH;
            OP_J:                    tgt = ST_JUMP;
            OP_JAL:                  tgt = jal_en ? ST_JUMP : ST_FETCH;
            default:                 tgt = ST_FETCH;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_perf_counter.sv
// Free-running wrap-around event counter used by the control unit performance
// monitor (only instantiated when CTRL_PERF_CNT_EN is defined).
module mc_perf_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Next-count computation.
    always_comb begin
        if (inc) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS datapath. Optional performance
// counters (cycle_cnt, instr_cnt) exist only when CTRL_PERF_CNT_EN is defined.
module multicycle_control_fsm
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter bit SUPPORT_JAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       instr_retired,
    output logic       illegal_op
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt
`endif
);

    state_e     state_d, state_q;
    logic [5:0] op_d, op_q;

    // Next-state and output decode; outputs are forced low while reset is held.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        alu_op        = ALUOP_NONE;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RT;
        pc_src        = PC_SRC_ALU;
        pc_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = REG_DST_RT;
        mem_to_reg    = MTR_ALUOUT;
        reg_write     = 1'b0;
        instr_retired = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALUOP_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else begin
                    state_d  = ST_FETCH;
                end
            end
            ST_DECODE: begin
                op_d      = opcode;
                alu_src_b = SRC_B_IMM_SH2;
                alu_op    = ALUOP_ADD;
                state_d   = decode_target(opcode, SUPPORT_JAL);
                if (state_d == ST_FETCH) begin
                    illegal_op    = 1'b1;
                    instr_retired = 1'b1;
                end else begin
                    illegal_op    = 1'b0;
                end
            end
            ST_EXEC_R: begin
                alu_src_a = SRC_A_RS;
                alu_op    = ALUOP_R;
                state_d   = ST_WB_R;
            end
            ST_WB_R: begin
                reg_dst       = REG_DST_RD;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_EXEC_I: begin
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_IMM;
                case (op_q)
                    OP_ORI:  alu_op = ALUOP_ORI;
                    OP_LUI:  alu_op = ALUOP_LUI;
                    default: alu_op = ALUOP_ADD;
                endcase
                state_d = ST_WB_I;
            end
            ST_WB_I: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_ADDR: begin
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_IMM;
                if (op_q == OP_SW) begin
                    alu_op  = ALUOP_SW;
                    state_d = ST_MEM_WR;
                end else begin
                    alu_op  = ALUOP_LW;
                    state_d = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = ST_WB_MEM;
                end else begin
                    state_d = ST_MEM_RD;
                end
            end
            ST_WB_MEM: begin
                mem_to_reg    = MTR_MDR;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_d       = ST_FETCH;
                end else begin
                    state_d       = ST_MEM_WR;
                end
            end
            ST_BRANCH: begin
                alu_src_a     = SRC_A_RS;
                alu_op        = ALUOP_BR;
                pc_src        = PC_SRC_ALUOUT;
                pc_write      = (op_q == OP_BNE) ? ~zero : zero;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src        = PC_SRC_JUMP;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                if (op_q == OP_JAL) begin
                    reg_dst    = REG_DST_RA;
                    mem_to_reg = MTR_PC;
                    reg_write  = 1'b1;
                end else begin
                    reg_write  = 1'b0;
                end
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (!reset) begin
            alu_op        = ALUOP_NONE;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            pc_src        = 2'b00;
            pc_write      = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 2'b00;
            mem_to_reg    = 2'b00;
            reg_write     = 1'b0;
            instr_retired = 1'b0;
            illegal_op    = 1'b0;
        end else begin
            illegal_op    = illegal_op;
        end
    end

    // State and latched-opcode registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            op_q    <= 6'b000000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    mc_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .count (cycle_cnt)
    );

    mc_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (instr_retired),
        .count (instr_cnt)
    );
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; counter checks are compiled in
// when CTRL_PERF_CNT_EN is defined.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'b000000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       instr_retired;
    logic       illegal_op;
`ifdef CTRL_PERF_CNT_EN
    logic [3:0] cycle_cnt;
    logic [3:0] instr_cnt;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [20:0] M_ALL = 21'h1FFFFF;
    localparam logic [20:0] M_SEL = 21'h003FFF;

    multicycle_control_fsm #(.CNT_WIDTH(4), .SUPPORT_JAL(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .pc_write      (pc_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .instr_retired (instr_retired),
        .illegal_op    (illegal_op)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [20:0] obs;
    assign obs = {alu_op, alu_src_a, alu_src_b, pc_src, pc_write, i_or_d, mem_read,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_retired, illegal_op};

    // Fields: alu,a,b,pc_src,pc_write,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,retired,illegal
    function automatic logic [20:0] mk(input logic [3:0] alu, input logic a, input logic [1:0] b,
                                       input logic [1:0] pcs, input logic pcw, input logic iod,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic [1:0] rd, input logic [1:0] mtr,
                                       input logic rw, input logic ret, input logic ill);
        return {alu, a, b, pcs, pcw, iod, mr, mw, irw, rd, mtr, rw, ret, ill};
    endfunction

    function automatic logic [20:0] fetch_vec(input logic rdy);
        return mk(4'b0100, 1'b0, 2'b01, 2'b00, rdy, 1'b0, 1'b1, 1'b0, rdy, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [20:0] decode_vec();
        return mk(4'b0100, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic cyc(input logic [5:0] op, input logic z, input logic mr);
        @(negedge clk);
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        opcode = 6'b000000; mem_ready = 1'b1; #1;
        total++;
        if (obs !== 21'h000000) begin
            bad++; $display("FAIL reset_outputs: got %h want %h", obs, 21'h000000);
        end
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0; #1;
        total++;
        if (obs !== fetch_vec(1'b0)) begin
            bad++; $display("FAIL reset_fetch: got %h want %h", obs, fetch_vec(1'b0));
        end
    endtask

    task automatic test_add();
        logic [20:0] e[4];
        logic [20:0] m[4];
        e[0] = fetch_vec(1'b1); m[0] = M_ALL;
        e[1] = decode_vec();    m[1] = M_ALL;
        e[2] = mk(4'b1111, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); m[2] = M_ALL;
        e[3] = mk(4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0); m[3] = M_SEL;
        for (int i = 0; i < 4; i++) begin
            cyc(6'b000000, 1'b0, 1'b1);
            total++;
            if ((obs & m[i]) !== (e[i] & m[i])) begin
                bad++; $display("FAIL add_c%0d: got %h want %h", i, obs & m[i], e[i] & m[i]);
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [20:0] e[7];
        logic [20:0] m[7];
        logic        r[7];
        e[0] = fetch_vec(1'b1); m[0] = M_ALL; r[0] = 1'b1;
        e[1] = decode_vec();    m[1] = M_ALL; r[1] = 1'b1;
        e[2] = mk(4'b0001, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); m[2] = M_ALL; r[2] = 1'b1;
        for (int i = 3; i < 6; i++) begin
            e[i] = mk(4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
            m[i] = M_SEL; r[i] = (i == 5);
        end
        e[6] = mk(4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0); m[6] = M_SEL; r[6] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(6'b100011, 1'b0, r[i]);
            total++;
            if ((obs & m[i]) !== (e[i] & m[i])) begin
                bad++; $display("FAIL lw_c%0d: got %h want %h", i, obs & m[i], e[i] & m[i]);
            end
        end
    endtask

    task automatic test_sw_fetch_wait();
        logic [20:0] e[5];
        logic [20:0] m[5];
        logic        r[5];
        e[0] = fetch_vec(1'b0); m[0] = M_ALL; r[0] = 1'b0;
        e[1] = fetch_vec(1'b1); m[1] = M_ALL; r[1] = 1'b1;
        e[2] = decode_vec();    m[2] = M_ALL; r[2] = 1'b1;
        e[3] = mk(4'b0010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); m[3] = M_ALL; r[3] = 1'b1;
        e[4] = mk(4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); m[4] = M_SEL; r[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(6'b101011, 1'b0, r[i]);
            total++;
            if ((obs & m[i]) !== (e[i] & m[i])) begin
                bad++; $display("FAIL sw_c%0d: got %h want %h", i, obs & m[i], e[i] & m[i]);
            end
        end
    endtask

    task automatic test_itype();
        logic [5:0]  ops[3];
        logic [3:0]  alus[3];
        logic [20:0] ex, wb;
        ops[0] = 6'b001000; alus[0] = 4'b0100;
        ops[1] = 6'b001101; alus[1] = 4'b0101;
        ops[2] = 6'b001111; alus[2] = 4'b0110;
        wb = mk(4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            ex = mk(alus[k], 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
            cyc(ops[k], 1'b0, 1'b1);
            cyc(ops[k], 1'b0, 1'b1);
            cyc(ops[k], 1'b0, 1'b1);
            total++;
            if (obs !== ex) begin
                bad++; $display("FAIL itype_exec op=%b: got %h want %h", ops[k], obs, ex);
            end
            cyc(ops[k], 1'b0, 1'b1);
            total++;
            if ((obs & M_SEL) !== (wb & M_SEL)) begin
                bad++; $display("FAIL itype_wb op=%b: got %h want %h", ops[k], obs & M_SEL, wb & M_SEL);
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0]  ops[4];
        logic        zs[4];
        logic        tk[4];
        logic [20:0] e;
        ops[0] = 6'b000100; zs[0] = 1'b1; tk[0] = 1'b1;
        ops[1] = 6'b000100; zs[1] = 1'b0; tk[1] = 1'b0;
        ops[2] = 6'b000101; zs[2] = 1'b0; tk[2] = 1'b1;
        ops[3] = 6'b000101; zs[3] = 1'b1; tk[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = mk(4'b0011, 1'b1, 2'b00, 2'b01, tk[k], 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
            cyc(ops[k], zs[k], 1'b1);
            cyc(ops[k], zs[k], 1'b1);
            total++;
            if (obs !== decode_vec()) begin
                bad++; $display("FAIL branch_decode k=%0d: got %h want %h", k, obs, decode_vec());
            end
            cyc(ops[k], zs[k], 1'b1);
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL branch k=%0d: got %h want %h", k, obs, e);
            end
        end
    endtask

    task automatic test_jump();
        logic [20:0] ej, ejal;
        ej   = mk(4'b0000, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        ejal = mk(4'b0000, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cyc((k == 0) ? 6'b000010 : 6'b000011, 1'b0, 1'b1);
            cyc((k == 0) ? 6'b000010 : 6'b000011, 1'b0, 1'b1);
            cyc((k == 0) ? 6'b000010 : 6'b000011, 1'b0, 1'b1);
            total++;
            if ((obs & M_SEL) !== (((k == 0) ? ej : ejal) & M_SEL)) begin
                bad++; $display("FAIL jump k=%0d: got %h want %h", k, obs & M_SEL, ((k == 0) ? ej : ejal) & M_SEL);
            end
        end
    endtask

    task automatic test_illegal();
        logic [20:0] e;
        e = mk(4'b0100, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        cyc(6'b111111, 1'b0, 1'b1);
        cyc(6'b111111, 1'b0, 1'b1);
        total++;
        if (obs !== e) begin
            bad++; $display("FAIL illegal_decode: got %h want %h", obs, e);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(6'b111111, 1'b0, 1'b0);
            total++;
            if (obs !== fetch_vec(1'b0)) begin
                bad++; $display("FAIL illegal_after_c%0d: got %h want %h", i, obs, fetch_vec(1'b0));
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [20:0] e;
        e = mk(4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(6'b101011, 1'b0, 1'b1);
        cyc(6'b101011, 1'b0, 1'b1);
        cyc(6'b101011, 1'b0, 1'b1);
        cyc(6'b101011, 1'b0, 1'b0);
        total++;
        if ((obs & M_SEL) !== (e & M_SEL)) begin
            bad++; $display("FAIL memwr_hold: got %h want %h", obs & M_SEL, e & M_SEL);
        end
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1; #1;
        total++;
        if (obs !== 21'h000000) begin
            bad++; $display("FAIL reset_in_memwr: got %h want %h", obs, 21'h000000);
        end
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0; #1;
        total++;
        if (obs !== fetch_vec(1'b0)) begin
            bad++; $display("FAIL fetch_after_reset: got %h want %h", obs, fetch_vec(1'b0));
        end
`ifdef CTRL_PERF_CNT_EN
        total++;
        if (cycle_cnt !== 4'd0 || instr_cnt !== 4'd0) begin
            bad++; $display("FAIL counters_after_reset: got %0d/%0d want 0/0", cycle_cnt, instr_cnt);
        end
`endif
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic test_perf_wrap();
        int pulses;
        pulses = 0;
        @(negedge clk);
        reset = 1'b0; #1;
        @(negedge clk);
        reset = 1'b1; opcode = 6'b000100; zero = 1'b1; mem_ready = 1'b1; #1;
        for (int i = 0; i < 16; i++) begin
            if (instr_retired) pulses++;
            @(negedge clk);
            #1;
        end
        total++;
        if (cycle_cnt !== 4'd0) begin
            bad++; $display("FAIL cycle_wrap: got %0d want 0", cycle_cnt);
        end
        total++;
        if (instr_cnt !== pulses[3:0] || pulses != 5) begin
            bad++; $display("FAIL instr_cnt: got %0d pulses %0d want 5", instr_cnt, pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_sw_fetch_wait();
        test_itype();
        test_branch();
        test_jump();
        test_illegal();
        test_reset_mid_write();
`ifdef CTRL_PERF_CNT_EN
        test_perf_wrap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
